// File: rtl/pwm_sr_pulse_gen.sv
// PWM set/reset pulse generator feeding the output RS flip-flop.
// A free-running sawtooth counter is compared against a double-buffered
// duty value. S fires one clock after count 0 and R fires one clock after
// count==duty, so the downstream RS_FF Q is high for exactly duty clocks
// per period. New duty values land in a shadow register and move to the
// active register only at the wrap edge, so a period is never cut short.
module pwm_sr_pulse_gen #(
  parameter int WIDTH  = 8,
  parameter int PERIOD = 199
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic [WIDTH-1:0] Duty_in,
  input  logic             Duty_load,
  output logic             S,
  output logic             R,
  output logic             Period_start,
  output logic [WIDTH-1:0] Duty_active
);

  // Terminal count and the 100% duty value (PERIOD+1 fits in WIDTH).
  localparam logic [WIDTH-1:0] LP_TC   = WIDTH'(PERIOD);
  localparam logic [WIDTH-1:0] LP_FULL = WIDTH'(PERIOD + 1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_active;
  logic             r_s;
  logic             r_r;
  logic             r_ps;

  logic [WIDTH-1:0] w_duty_clamped;
  logic             w_wrap;
  logic             w_at_zero;

  // Anything above 100% saturates to a full-period high time.
  assign w_duty_clamped = (Duty_in > LP_FULL) ? LP_FULL : Duty_in;
  assign w_wrap         = En && (r_count == LP_TC);
  assign w_at_zero      = (r_count == '0);

  // Sawtooth period counter; holds while En is low.
  always_ff @(posedge Clk) begin
    if (Rst)        r_count <= '0;
    else if (w_wrap) r_count <= '0;
    else if (En)    r_count <= r_count + 1'b1;
  end

  // Shadow duty: any load strobe writes it, independent of En.
  always_ff @(posedge Clk) begin
    if (Rst)            r_shadow <= '0;
    else if (Duty_load) r_shadow <= w_duty_clamped;
  end

  // Active duty: updated only at the wrap edge; a load on that same edge
  // bypasses the shadow so it is not delayed by a full period.
  always_ff @(posedge Clk) begin
    if (Rst)         r_active <= '0;
    else if (w_wrap) r_active <= Duty_load ? w_duty_clamped : r_shadow;
  end

  // Registered S/R/Period_start decode. R is held high in reset so the
  // downstream RS_FF is cleared. At 100% duty count never equals the duty
  // value, and at 0% R lands on count 0 while S is suppressed, so S and R
  // can never coincide.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_s  <= 1'b0;
      r_r  <= 1'b1;
      r_ps <= 1'b0;
    end else if (!En) begin
      r_s  <= 1'b0;
      r_r  <= 1'b0;
      r_ps <= 1'b0;
    end else begin
      r_ps <= w_at_zero;
      r_s  <= w_at_zero && (r_active != '0);
      r_r  <= (r_count == r_active) && (r_active <= LP_TC);
    end
  end

  assign S            = r_s;
  assign R            = r_r;
  assign Period_start = r_ps;
  assign Duty_active  = r_active;

endmodule
